// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM encodings, digit width
// and a helper that sizes the BCD field for a given binary width.
package bcd_pkg;

  localparam int BCD_DIG_W = 4;

  localparam logic [1:0] ST_IDLE_ENC = 2'b00;
  localparam logic [1:0] ST_OP_ENC   = 2'b01;
  localparam logic [1:0] ST_DONE_ENC = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_OP   = ST_OP_ENC,
    ST_DONE = ST_DONE_ENC
  } state_t;

  // Number of decimal digits needed to print 2^w-1.
  function automatic int dec_digits(input int w);
    longint unsigned v;
    int              n;
    v = (64'd1 << w) - 64'd1;
    n = 0;
    do begin
      n++;
      v = v / 64'd10;
    end while (v != 64'd0);
    return n;
  endfunction

endpackage

// File: rtl/bin2bcd_conv_if.sv
// Start/ready/done handshake plus data for the binary-to-BCD converter.
// The master supplies operands; the converter sits on the slave side.
interface bin2bcd_conv_if
  import bcd_pkg::*;
#(
  parameter int W = 20,
  parameter int D = 7
) ();

  logic                   start;
  logic [W-1:0]           bin;
  logic                   ready;
  logic                   done_tick;
  logic [BCD_DIG_W*D-1:0] bcd;

  modport master (output start, bin, input ready, done_tick, bcd);
  modport slave  (input start, bin, output ready, done_tick, bcd);

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so the following
// left shift carries correctly into the next decimal place.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIG_W-1:0] d,
  output logic [BCD_DIG_W-1:0] q
);

  assign q = (d > 4'd4) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3), W op cycles per result.
// FSMD: one next-state/next-data block feeding one register block.
module bin2bcd_conv
  import bcd_pkg::*;
#(
  parameter int W = 20,
  parameter int D = dec_digits(W)
) (
  input  logic           clk,
  input  logic           reset,
  bin2bcd_conv_if.slave  bus
);

  localparam int BW = BCD_DIG_W * D;
  localparam int SW = BW + W;
  localparam int CW = $clog2(W + 1);

  state_t          state_q, state_n;
  logic [SW-1:0]   sh_q, sh_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [BW-1:0]   bcd_q, bcd_n;
  logic [BW-1:0]   adj;
  logic            ready_q, ready_n;
  logic            done_q, done_n;

  for (genvar i = 0; i < D; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (sh_q[W + BCD_DIG_W*i +: BCD_DIG_W]),
      .q (adj[BCD_DIG_W*i +: BCD_DIG_W])
    );
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_n = state_q;
    sh_n    = sh_q;
    cnt_n   = cnt_q;
    bcd_n   = bcd_q;
    done_n  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          sh_n    = SW'(bus.bin);
          cnt_n   = CW'(W);
          state_n = ST_OP;
        end
      end
      ST_OP: begin
        sh_n  = {adj, sh_q[W-1:0]} << 1;
        cnt_n = cnt_q - CW'(1);
        // Last shift: capture the result now so bcd is already valid during done.
        if (cnt_q == CW'(1)) begin
          bcd_n   = sh_n[SW-1:W];
          done_n  = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase

    ready_n = (state_n == ST_IDLE);
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      sh_q    <= sh_n;
      cnt_q   <= cnt_n;
      bcd_q   <= bcd_n;
      ready_q <= ready_n;
      done_q  <= done_n;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done_tick = done_q;
  assign bus.bcd       = bcd_q;

endmodule

// File: tb/tb_bin2bcd_conv.sv
// Self-checking bench for bin2bcd_conv: directed corner cases, handshake timing,
// mid-conversion reset, a Fibonacci-producer chain and random operands.
module tb_bin2bcd_conv;

  localparam int W = 20;
  localparam int D = 7;
  localparam int LAT = W + 1;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  bin2bcd_conv_if #(.W(W), .D(D)) bus ();

  bin2bcd_conv #(.W(W), .D(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: peel decimal digits off with plain arithmetic.
  function automatic logic [4*D-1:0] bcd_model(input logic [W-1:0] v);
    int unsigned     x;
    logic [4*D-1:0]  r;
    x = v;
    r = '0;
    for (int k = 0; k < D; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic longint unsigned fib(input int i);
    longint unsigned a, b, t;
    a = 0;
    b = 1;
    for (int k = 0; k < i; k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // One conversion with start pulsed for a single cycle; bin is scrambled after
  // the accepting edge to show the operand was captured.
  task automatic run_conv(input logic [W-1:0] v, input logic [4*D-1:0] exp, input string tag);
    int k;
    bit seen;
    @(negedge clk);
    check({tag, "_ready_idle"}, 32'(bus.ready), 32'd1);
    bus.start = 1'b1;
    bus.bin   = v;
    seen = 1'b0;
    k = 0;
    while (!seen && k < LAT + 20) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        bus.start = 1'b0;
        bus.bin   = W'($urandom);
        check({tag, "_ready_op"}, 32'(bus.ready), 32'd0);
      end
      if (bus.done_tick) seen = 1'b1;
    end
    check({tag, "_latency"}, 32'(k), 32'(LAT));
    check({tag, "_bcd"}, 32'(bus.bcd), 32'(exp));
    check({tag, "_ready_done"}, 32'(bus.ready), 32'd0);
    @(negedge clk);
    check({tag, "_ready_back"}, 32'(bus.ready), 32'd1);
    check({tag, "_tick_width"}, 32'(bus.done_tick), 32'd0);
    check({tag, "_bcd_hold"}, 32'(bus.bcd), 32'(exp));
  endtask

  // Stand-in for the upstream Fibonacci FSMD: some compute cycles, then its
  // done_tick drives start with f on bin.
  task automatic fib_chain(input int i, input logic [4*D-1:0] exp, input string tag);
    longint unsigned f;
    f = fib(i);
    repeat (i % 5 + 1) @(negedge clk);
    run_conv(W'(f), exp, tag);
  endtask

  initial begin
    int              k;
    int              ticks;
    int              first_k;
    int              last_k;
    int              idx;
    logic [W-1:0]    a;
    logic [4*D-1:0]  got;
    logic [W-1:0]    vals [3];

    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.bin   = '0;

    #1;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done", 32'(bus.done_tick), 32'd0);
    check("rst_bcd", 32'(bus.bcd), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Directed values, expected results written out as literals.
    run_conv(20'd832040, 28'h0832040, "fib30");
    run_conv(20'd0,      28'h0000000, "zero");
    run_conv(20'hFFFFF,  28'h1048575, "max");
    run_conv(20'd9,      28'h0000009, "nine");

    // Start pulsed during op is ignored and not queued; bin changes do nothing.
    a = 20'd654321;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = a;
    ticks = 0;
    first_k = 0;
    got = '0;
    for (k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      if (k == 5) begin
        bus.start = 1'b1;
        bus.bin   = 20'd1;
      end
      if (k == 6) begin
        bus.start = 1'b0;
        bus.bin   = 20'd777;
      end
      if (bus.done_tick) begin
        ticks++;
        if (first_k == 0) begin
          first_k = k;
          got = bus.bcd;
        end
      end
    end
    check("ign_latency", 32'(first_k), 32'(LAT));
    check("ign_bcd", 32'(got), 32'h0654321);
    check("ign_ticks", 32'(ticks), 32'd1);

    // Reset in op cycle 10 aborts the conversion.
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 20'd123456;
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_bcd", 32'(bus.bcd), 32'd0);
    check("abort_done", 32'(bus.done_tick), 32'd0);
    reset = 1'b0;
    ticks = 0;
    for (k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus.done_tick) ticks++;
    end
    check("abort_no_tick", 32'(ticks), 32'd0);
    run_conv(20'd42, 28'h0000042, "after_abort");

    // Chained behind the Fibonacci producer.
    fib_chain(30, 28'h0832040, "chain_i30");
    fib_chain(0,  28'h0000000, "chain_i0");
    fib_chain(1,  28'h0000001, "chain_i1");

    // Start held high: back-to-back conversions, one every W+2 cycles.
    vals[0] = 20'd1;
    vals[1] = 20'd10;
    vals[2] = 20'd99;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = vals[0];
    idx = 0;
    last_k = 0;
    for (k = 1; k <= 90 && idx < 3; k++) begin
      @(negedge clk);
      if (bus.done_tick) begin
        check($sformatf("hold_spacing_%0d", idx), 32'(k - last_k), (idx == 0) ? 32'(LAT) : 32'(W + 2));
        check($sformatf("hold_bcd_%0d", idx), 32'(bus.bcd), 32'(bcd_model(vals[idx])));
        last_k = k;
        idx++;
        if (idx < 3) bus.bin = vals[idx];
        else bus.start = 1'b0;
      end else if (idx > 0) begin
        check($sformatf("hold_stable_%0d", idx), 32'(bus.bcd), 32'(bcd_model(vals[idx-1])));
      end
    end
    check("hold_count", 32'(idx), 32'd3);
    repeat (W + 4) @(negedge clk);

    // Random operands against the arithmetic model.
    for (int r = 0; r < 10; r++) begin
      a = W'($urandom_range(0, (1 << W) - 1));
      run_conv(a, bcd_model(a), $sformatf("rand_%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
